// File: rtl/iq_src_pkg.sv
// Shared types for the IQ frame source: sample word layout and FSM encoding.
package iq_src_pkg;
  localparam int IQ_DW = 12;
  localparam int W_DW  = 4;

  typedef struct packed {
    logic signed [IQ_DW-1:0] i;
    logic signed [IQ_DW-1:0] q;
    logic        [W_DW-1:0]  w_i;
    logic        [W_DW-1:0]  w_q;
  } iq_sample_t;

  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_DONE, ST_GAP} src_state_e;
endpackage

// File: rtl/iq_sample_fifo.sv
// Synchronous sample FIFO; read data is registered and reads back zero on
// cycles without a pop, so the frame source can drive it straight out.
module iq_sample_fifo
  import iq_src_pkg::*;
#(
  parameter  int DEPTH = 32,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic       clk,
  input  logic       rstb,
  input  logic       push,
  input  logic       pop,
  input  iq_sample_t wdata,
  output iq_sample_t rdata,
  output logic       full,
  output logic       empty,
  output logic [AW:0] level
);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0] r_wptr, r_rptr;
  iq_sample_t  r_rdata;
  iq_sample_t  r_mem [DEPTH];

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_rdata <= '0;
    end else begin
      if (push) r_wptr <= r_wptr + PTR_ONE;
      if (pop)  r_rptr <= r_rptr + PTR_ONE;
      r_rdata <= pop ? r_mem[r_rptr[AW-1:0]] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) r_mem[r_wptr[AW-1:0]] <= wdata;
  end

  assign rdata = r_rdata;
  assign level = r_wptr - r_rptr;
  assign full  = (level == (AW+1)'(DEPTH));
  assign empty = (level == '0);
endmodule

// File: rtl/iq_frame_source.sv
// Buffers upstream IQ samples and emits fixed-length gap-free frames,
// each followed by a one-cycle done strobe and an enforced idle gap.
module iq_frame_source
  import iq_src_pkg::*;
#(
  parameter  int FRAME_LEN = 16,
  parameter  int DEPTH     = 32,
  parameter  int GAP       = 2,
  localparam int LW        = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [IQ_DW-1:0] s_data_i,
  input  logic [IQ_DW-1:0] s_data_q,
  input  logic [W_DW-1:0]  s_w_i,
  input  logic [W_DW-1:0]  s_w_q,
  input  logic             start,
  output logic [IQ_DW-1:0] in_data_i,
  output logic [IQ_DW-1:0] in_data_q,
  output logic [W_DW-1:0]  in_w_i,
  output logic [W_DW-1:0]  in_w_q,
  output logic             in_en,
  output logic             done,
  output logic             busy,
  output logic [LW-1:0]    level
);
  src_state_e r_state, w_state_nxt;
  logic [LW-1:0] r_cnt, w_cnt_nxt;
  logic [3:0]    r_gcnt, w_gcnt_nxt;
  logic          r_pend, w_pend_nxt;
  logic          r_in_en, r_done, r_busy;
  logic          w_full, w_empty, w_push, w_pop, w_go;
  logic [LW-1:0] w_level;
  iq_sample_t    w_wdata, w_rdata;

  assign w_wdata = {s_data_i, s_data_q, s_w_i, s_w_q};
  assign w_push  = s_valid && !w_full;
  assign w_go    = (r_pend || start) && (w_level >= LW'(FRAME_LEN)) && !w_empty;

  iq_sample_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rstb  (rstb),
    .push  (w_push),
    .pop   (w_pop),
    .wdata (w_wdata),
    .rdata (w_rdata),
    .full  (w_full),
    .empty (w_empty),
    .level (w_level)
  );

  // The state register is aligned with the outputs: SEND covers exactly the
  // in_en cycles, so the FIFO is popped whenever the next state is SEND.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_gcnt_nxt  = r_gcnt;
    w_pend_nxt  = r_pend;
    case (r_state)
      ST_IDLE: begin
        if (w_go) begin
          w_state_nxt = ST_SEND;
          w_cnt_nxt   = '0;
          w_pend_nxt  = 1'b0;
        end else if (start) begin
          w_pend_nxt  = 1'b1;
        end
      end
      ST_SEND: begin
        if (r_cnt == LW'(FRAME_LEN-1)) w_state_nxt = ST_DONE;
        else                           w_cnt_nxt   = r_cnt + LW'(1);
      end
      ST_DONE: begin
        w_gcnt_nxt = '0;
        if (GAP > 0) w_state_nxt = ST_GAP;
        else         w_state_nxt = ST_IDLE;
      end
      ST_GAP: begin
        if (r_gcnt == 4'(GAP-1)) w_state_nxt = ST_IDLE;
        else                     w_gcnt_nxt  = r_gcnt + 4'd1;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_pop = (w_state_nxt == ST_SEND);

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_gcnt  <= '0;
      r_pend  <= 1'b0;
      r_in_en <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_gcnt  <= w_gcnt_nxt;
      r_pend  <= w_pend_nxt;
      r_in_en <= w_pop;
      r_done  <= (w_state_nxt == ST_DONE);
      r_busy  <= (w_state_nxt != ST_IDLE) || w_pend_nxt;
    end
  end

  assign s_ready   = !w_full;
  assign level     = w_level;
  assign in_en     = r_in_en;
  assign done      = r_done;
  assign busy      = r_busy;
  assign in_data_i = w_rdata.i;
  assign in_data_q = w_rdata.q;
  assign in_w_i    = w_rdata.w_i;
  assign in_w_q    = w_rdata.w_q;
endmodule

// File: tb/tb_iq_frame_source.sv
// Directed bench for iq_frame_source: frame timing, pending start,
// backpressure, back-to-back frames and mid-frame reset.
module tb_iq_frame_source;
  logic        clk = 1'b0, rstb = 1'b0, s_valid = 1'b0, start = 1'b0;
  logic [11:0] s_data_i = '0, s_data_q = '0;
  logic [3:0]  s_w_i = '0, s_w_q = '0;
  logic        s_ready, in_en, done, busy;
  logic [11:0] in_data_i, in_data_q;
  logic [3:0]  in_w_i, in_w_q;
  logic [5:0]  level;

  iq_frame_source #(.FRAME_LEN(16), .DEPTH(32), .GAP(2)) dut (
    .clk(clk), .rstb(rstb), .s_valid(s_valid), .s_ready(s_ready),
    .s_data_i(s_data_i), .s_data_q(s_data_q), .s_w_i(s_w_i), .s_w_q(s_w_q),
    .start(start), .in_data_i(in_data_i), .in_data_q(in_data_q),
    .in_w_i(in_w_i), .in_w_q(in_w_q), .in_en(in_en), .done(done),
    .busy(busy), .level(level)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input int n);
    logic [11:0] a, b;
    a = 12'(n);
    b = 12'(-n);
    return {a, b, 4'(n), 4'(15 - n)};
  endfunction

  // Observes outputs mid-cycle, away from the active edge.
  int          en_cyc[$], done_cyc[$];
  logic [31:0] en_dat[$];
  int          acc = 0, overlap = 0, zero_bad = 0;
  always @(negedge clk) begin
    if (rstb) begin
      if (in_en) begin
        en_cyc.push_back(cyc);
        en_dat.push_back({in_data_i, in_data_q, in_w_i, in_w_q});
      end else if ({in_data_i, in_data_q, in_w_i, in_w_q} != '0) begin
        zero_bad++;
      end
      if (done) done_cyc.push_back(cyc);
      if (in_en && done) overlap++;
      if (s_valid && s_ready) acc++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int n);
    s_data_i = 12'(n);
    s_data_q = 12'(-n);
    s_w_i    = 4'(n);
    s_w_q    = 4'(15 - n);
  endtask

  task automatic push(input int n);
    s_valid = 1'b1;
    drive(n);
    tick();
    s_valid = 1'b0;
  endtask

  task automatic pulse_start(output int k);
    k = cyc;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int n, input string tag);
    int b = 0;
    while (done_cyc.size() < n && b < 300) begin
      tick();
      b++;
    end
    chk(tag, 32'(done_cyc.size()), 32'(n));
  endtask

  task automatic clear_q();
    en_cyc.delete();
    en_dat.delete();
    done_cyc.delete();
  endtask

  initial begin
    int k, p, b, bad;

    // reset state
    #2;
    chk("rst_ready", 32'(s_ready), 32'd1);
    chk("rst_outs", 32'({in_en, done, busy, level, in_data_i, in_w_i}), 32'd0);
    tick(); tick();
    rstb = 1'b1;
    repeat (3) tick();

    // basic frame
    clear_q();
    for (int n = 0; n < 16; n++) push(n);
    chk("basic_level16", 32'(level), 32'd16);
    pulse_start(k);
    wait_done(1, "basic_done");
    chk("basic_count", 32'(en_dat.size()), 32'd16);
    if (en_dat.size() == 16) begin
      for (int n = 0; n < 16; n++) chk($sformatf("basic_s%0d", n), en_dat[n], mk(n));
      chk("basic_first_cyc", 32'(en_cyc[0]), 32'(k + 1));
      chk("basic_last_cyc", 32'(en_cyc[15]), 32'(k + 16));
    end
    chk("basic_done_cyc", 32'(done_cyc[0]), 32'(k + 17));
    chk("basic_level0", 32'(level), 32'd0);
    repeat (5) tick();
    chk("basic_idle", 32'(busy), 32'd0);

    // pending start waits for data
    clear_q();
    for (int n = 100; n < 105; n++) push(n);
    pulse_start(k);
    chk("pend_busy", 32'(busy), 32'd1);
    p = 0;
    for (int n = 105; n < 116; n++) begin
      p = cyc;
      push(n);
      if (n < 115) repeat (2) tick();
    end
    chk("pend_no_en", 32'(en_dat.size()), 32'd0);
    chk("pend_busy2", 32'(busy), 32'd1);
    wait_done(1, "pend_done");
    if (en_dat.size() == 16) begin
      chk("pend_first_cyc", 32'(en_cyc[0]), 32'(p + 2));
      chk("pend_first", en_dat[0], mk(100));
      chk("pend_last", en_dat[15], mk(115));
    end else chk("pend_count", 32'(en_dat.size()), 32'd16);

    // full / backpressure
    repeat (6) tick();
    clear_q();
    acc = 0;
    s_valid = 1'b1;
    for (int n = 0; n < 40; n++) begin
      drive(200 + n);
      tick();
    end
    s_valid = 1'b0;
    chk("full_accepted", 32'(acc), 32'd32);
    chk("full_level", 32'(level), 32'd32);
    chk("full_ready", 32'(s_ready), 32'd0);
    pulse_start(k);
    chk("full_reopen", 32'(s_ready), 32'd1);
    chk("full_level31", 32'(level), 32'd31);
    wait_done(1, "full_done");
    if (en_dat.size() == 16) begin
      chk("full_first", en_dat[0], mk(200));
      chk("full_last", en_dat[15], mk(215));
    end else chk("full_count", 32'(en_dat.size()), 32'd16);
    repeat (5) tick();
    chk("full_left", 32'(level), 32'd16);

    // back-to-back frames with start held
    clear_q();
    start = 1'b1;
    for (int n = 300; n < 332; n++) push(n);
    wait_done(3, "b2b_done");
    start = 1'b0;
    chk("b2b_count", 32'(en_dat.size()), 32'd48);
    if (en_dat.size() == 48) begin
      bad = 0;
      for (int i = 1; i < 48; i++)
        if ((i % 16) != 0 && en_cyc[i] != en_cyc[i-1] + 1) bad++;
      chk("b2b_contig", 32'(bad), 32'd0);
      chk("b2b_sep1", 32'(en_cyc[16] - en_cyc[15]), 32'd5);
      chk("b2b_sep2", 32'(en_cyc[32] - en_cyc[31]), 32'd5);
      chk("b2b_done_pos", 32'(done_cyc[0]), 32'(en_cyc[15] + 1));
      chk("b2b_f1", en_dat[0], mk(216));
      chk("b2b_f2", en_dat[16], mk(300));
      chk("b2b_f3", en_dat[47], mk(331));
    end
    repeat (5) tick();
    chk("b2b_idle", 32'(busy), 32'd0);

    // abort mid-frame with reset
    clear_q();
    for (int n = 400; n < 416; n++) push(n);
    pulse_start(k);
    b = 0;
    while (!(in_en && in_data_i == 12'd406) && b < 40) begin
      tick();
      b++;
    end
    chk("abort_at7", 32'(in_data_i), 32'd406);
    rstb = 1'b0;
    #1;
    chk("abort_ready", 32'(s_ready), 32'd1);
    chk("abort_outs", 32'({in_en, done, busy, level, in_data_i}), 32'd0);
    clear_q();
    repeat (2) tick();
    rstb = 1'b1;
    repeat (30) tick();
    chk("abort_no_done", 32'(done_cyc.size()), 32'd0);
    chk("abort_no_en", 32'(en_dat.size()), 32'd0);
    chk("abort_level", 32'(level), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    for (int n = 500; n < 516; n++) push(n);
    pulse_start(k);
    wait_done(1, "post_done");
    if (en_dat.size() == 16) begin
      chk("post_first", en_dat[0], mk(500));
      chk("post_last", en_dat[15], mk(515));
    end else chk("post_count", 32'(en_dat.size()), 32'd16);
    tick();
    chk("post_level", 32'(level), 32'd0);

    chk("en_done_overlap", 32'(overlap), 32'd0);
    chk("idle_data_zero", 32'(zero_bad), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
